// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and the default bit period.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level; both flops reset to 1 (idle line).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, registered byte/valid/frame-error outputs.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            out_d       = shift_q;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BREAK: begin
        // Line held low after a bad stop bit must not be mistaken for a new start bit.
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 8 clocks per bit.
module tb_uart_rx;

  localparam int BIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] out;
  logic       out_valid;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int         valid_cnt = 0;
  int         err_cnt   = 0;
  bit         both_seen = 1'b0;
  logic [7:0] cap[$];

  uart_rx #(.CLKS_PER_BIT(BIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .out       (out),
    .out_valid (out_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles, so a pulse held two cycles shows up as two.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        valid_cnt++;
        cap.push_back(out);
      end
      if (frame_err) err_cnt++;
      if (out_valid && frame_err) both_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop, input int gap);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int         v0, e0, c0;
    logic [7:0] vals[256];

    rx  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out", out, 8'h00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte 'a'
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h61, 1'b1, 2);
    check("a_pulses", valid_cnt - v0, 1);
    check("a_out", out, 8'h61);
    check("a_upper", to_upper(out), 8'h41);
    check("a_ferr", err_cnt - e0, 0);

    // Back-to-back frames, no idle gap
    v0 = valid_cnt; e0 = err_cnt; c0 = cap.size();
    send_byte(8'h48, 1'b1, 0);
    send_byte(8'h7A, 1'b1, 3);
    check("b2b_pulses", valid_cnt - v0, 2);
    check("b2b_first", (cap.size() > c0) ? cap[c0] : 8'hxx, 8'h48);
    check("b2b_second", (cap.size() > c0 + 1) ? cap[c0+1] : 8'hxx, 8'h7A);
    check("b2b_ferr", err_cnt - e0, 0);

    // Start-bit glitch of 3 cycles
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy_hi", busy, 1'b1);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_ferr", err_cnt - e0, 0);

    // Bad stop bit, line then held low
    v0 = valid_cnt; e0 = err_cnt;
    send_byte(8'h55, 1'b0, 0);
    repeat (10) @(negedge clk);
    check("ferr_pulses", err_cnt - e0, 1);
    check("ferr_valid", valid_cnt - v0, 0);
    check("ferr_out_kept", out, 8'h7A);
    check("ferr_busy_low_line", busy, 1'b1);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("ferr_busy_released", busy, 1'b0);

    // Reset in the middle of bit 4 of 8'hC3
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rx = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    check("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_out", out, 8'h00);
    check("mid_rst_valid", out_valid, 1'b0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_idle", busy, 1'b0);
    v0 = valid_cnt;
    send_byte(8'h30, 1'b1, 4);
    check("mid_pulses", valid_cnt - v0, 1);
    check("mid_out", out, 8'h30);

    // All 256 values, shuffled, random idle gaps
    for (int i = 0; i < 256; i++) vals[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int         j;
      logic [7:0] t;
      j       = $urandom_range(0, i);
      t       = vals[i];
      vals[i] = vals[j];
      vals[j] = t;
    end
    v0 = valid_cnt; e0 = err_cnt; c0 = cap.size();
    for (int i = 0; i < 256; i++) send_byte(vals[i], 1'b1, $urandom_range(0, 20));
    repeat (20) @(negedge clk);
    check("all_count", valid_cnt - v0, 256);
    check("all_ferr", err_cnt - e0, 0);
    for (int i = 0; i < 256; i++) begin
      check($sformatf("all_val%0d", i), (cap.size() > c0 + i) ? cap[c0+i] : 8'hxx, vals[i]);
    end

    check("never_both", both_seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-005 SHALL have port out, output, 8, last correctly framed byte; drives toUpper in directly.
REQ-006 SHALL have port out_valid, output, 1, one-cycle pulse when out updates.
REQ-007 SHALL have port frame_err, output, 1, one-cycle pulse when stop bit sampled low.
REQ-008 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions use synchronized rx_s only.
REQ-010 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-011 IDLE: rx_s==0 -> START with bit counter cleared.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer divide), sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
REQ-013 DATA: sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first, into shift register; after 8th -> STOP.
REQ-014 STOP: sample rx_s CLKS_PER_BIT cycles after 8th data sample.
REQ-015 Stop sample 1: out <= shift register and out_valid = 1 on the next clock edge, held exactly one cycle; -> IDLE.
REQ-016 Stop sample 0: frame_err pulses one cycle, out unchanged, out_valid stays 0; -> BREAK.
REQ-017 BREAK: remain until rx_s==1, then -> IDLE; no new frame detected while line held low.
REQ-018 out SHALL hold its value between valid pulses; out_valid and frame_err never high in the same cycle.
REQ-019 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.
REQ-020 Cycle counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; bit index 3 bits; no wrap-around inside a bit period.
REQ-021 Start-bit glitch shorter than CLKS_PER_BIT/2 cycles SHALL produce no output pulse.

Reset
REQ-022 rst high SHALL immediately force state IDLE, out=8'h00, out_valid=0, frame_err=0, busy=0, counters 0, synchronizer flops 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte; after release, reception resumes at the next falling edge of rx.

Structure
REQ-024 State encoding and the default CLKS_PER_BIT constant SHALL live in shared package uart_pkg.
REQ-025 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value 1).
REQ-026 No combinational path from rx to any output.

Verification (CLKS_PER_BIT=8)
REQ-027 Send 8'h61 ('a'), 8N1 -> out=8'h61, out_valid one cycle; toUpper output 8'h41.
REQ-028 Back-to-back 8'h48, 8'h7A with no idle gap -> two valid pulses, out 8'h48 then 8'h7A, frame_err 0.
REQ-029 rx low for 3 cycles then high -> no out_valid, no frame_err, busy returns 0.
REQ-030 Send 8'h55 with stop bit 0 -> frame_err one pulse, out keeps prior value, busy until rx returns high.
REQ-031 Assert rst during bit 4 of 8'hC3, release, send 8'h30 -> out_valid once, out=8'h30.
REQ-032 Send all 256 byte values random order, random idle gaps 0..20 cycles -> each value observed exactly once in order.
